// File: rtl/paddle_repeat_ctrl_pkg.sv
// Shared encodings and default timing for the paddle auto-repeat controller.
// The paddle position logic imports the same constants.
package paddle_repeat_ctrl_pkg;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DELAY  = 2'd1;
  localparam logic [1:0] S_REPEAT = 2'd2;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // 200 ms first repeat and 50 ms cadence at 125 MHz
  localparam int DEFAULT_CNT_WIDTH     = 25;
  localparam int DEFAULT_DELAY_CYCLES  = 25_000_000;
  localparam int DEFAULT_REPEAT_CYCLES = 6_250_000;

endpackage

// File: rtl/paddle_repeat_ctrl_timer.sv
// Up-counting cycle timer for the auto-repeat FSM.
// Expires while the count equals the supplied limit.
module repeat_timer #(
  parameter int CNT_WIDTH = 25
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_clear,
  input  logic [CNT_WIDTH-1:0] i_limit,
  output logic                 o_expire
);

  logic [CNT_WIDTH-1:0] count;

  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear) begin
      count <= '0;
    end else begin
      count <= count + CNT_WIDTH'(1);
    end
  end

  assign o_expire = (count == i_limit);

endmodule

// File: rtl/paddle_repeat_ctrl.sv
// Typematic auto-repeat for one player's up/down buttons: one move per press,
// then a delayed first repeat and a steady repeat cadence while held.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   S_IDLE   | waiting for a single push while enabled
//   S_DELAY  | move issued, timing DELAY_CYCLES to the first repeat
//   S_REPEAT | repeating, one move every REPEAT_CYCLES while held
module paddle_repeat_ctrl
  import paddle_repeat_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH     = DEFAULT_CNT_WIDTH,
  parameter int DELAY_CYCLES  = DEFAULT_DELAY_CYCLES,
  parameter int REPEAT_CYCLES = DEFAULT_REPEAT_CYCLES
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_enable,
  input  logic i_up_level,
  input  logic i_up_push,
  input  logic i_down_level,
  input  logic i_down_push,
  output logic o_move_up,
  output logic o_move_down,
  output logic o_active
);

  localparam logic [CNT_WIDTH-1:0] DELAY_LIMIT  = CNT_WIDTH'(DELAY_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] REPEAT_LIMIT = CNT_WIDTH'(REPEAT_CYCLES - 1);

  logic [1:0]           state, state_nxt;
  logic                 dir, dir_nxt;
  logic                 up_nxt, down_nxt;
  logic                 clear, expire, grace;
  logic                 opp_push, dir_level;
  logic [CNT_WIDTH-1:0] limit;

  assign limit     = (state == S_REPEAT) ? REPEAT_LIMIT : DELAY_LIMIT;
  assign opp_push  = (dir == DIR_UP) ? i_down_push : i_up_push;
  assign dir_level = (dir == DIR_UP) ? i_up_level : i_down_level;

  repeat_timer #(.CNT_WIDTH(CNT_WIDTH)) u_timer (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_clear  (clear),
    .i_limit  (limit),
    .o_expire (expire)
  );

  always_comb begin
    state_nxt = state;
    dir_nxt   = dir;
    up_nxt    = 1'b0;
    down_nxt  = 1'b0;
    clear     = 1'b0;
    if (!i_enable) begin
      state_nxt = S_IDLE;
      clear     = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          clear = 1'b1;
          if (i_up_push ^ i_down_push) begin
            dir_nxt   = i_down_push ? DIR_DOWN : DIR_UP;
            up_nxt    = i_up_push;
            down_nxt  = i_down_push;
            state_nxt = S_DELAY;
          end
        end
        S_DELAY, S_REPEAT: begin
          if (opp_push) begin
            dir_nxt   = ~dir;
            up_nxt    = (dir == DIR_DOWN);
            down_nxt  = (dir == DIR_UP);
            state_nxt = S_DELAY;
            clear     = 1'b1;
          end else if (!dir_level && !grace) begin
            // grace covers the first cycle, where the level may lag its push
            state_nxt = S_IDLE;
            clear     = 1'b1;
          end else if (expire) begin
            up_nxt    = (dir == DIR_UP);
            down_nxt  = (dir == DIR_DOWN);
            state_nxt = S_REPEAT;
            clear     = 1'b1;
          end
        end
        default: begin
          state_nxt = S_IDLE;
          clear     = 1'b1;
        end
      endcase
    end
  end

  // grace tracks count==0: high the cycle after any clear
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state       <= S_IDLE;
      dir         <= DIR_UP;
      grace       <= 1'b1;
      o_move_up   <= 1'b0;
      o_move_down <= 1'b0;
      o_active    <= 1'b0;
    end else begin
      state       <= state_nxt;
      dir         <= dir_nxt;
      grace       <= clear;
      o_move_up   <= up_nxt;
      o_move_down <= down_nxt;
      o_active    <= (state_nxt != S_IDLE);
    end
  end

endmodule

// File: tb/tb_paddle_repeat_ctrl.sv
// Directed bench for paddle_repeat_ctrl with DELAY_CYCLES=10, REPEAT_CYCLES=4.
module tb_paddle_repeat_ctrl;

  logic i_clock = 1'b0;
  logic i_reset, i_enable;
  logic i_up_level, i_up_push, i_down_level, i_down_push;
  logic o_move_up, o_move_down, o_active;
  int   checks = 0;
  int   errors = 0;

  always #5 i_clock = ~i_clock;

  paddle_repeat_ctrl #(.CNT_WIDTH(8), .DELAY_CYCLES(10), .REPEAT_CYCLES(4)) dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_enable     (i_enable),
    .i_up_level   (i_up_level),
    .i_up_push    (i_up_push),
    .i_down_level (i_down_level),
    .i_down_push  (i_down_push),
    .o_move_up    (o_move_up),
    .o_move_down  (o_move_down),
    .o_active     (o_active)
  );

  task automatic step();
    @(posedge i_clock);
    #1;
  endtask

  task automatic clear_inputs();
    i_enable = 1'b1; i_up_level = 1'b0; i_up_push = 1'b0;
    i_down_level = 1'b0; i_down_push = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    i_reset = 1'b1;
    step(); step();
    i_reset = 1'b0;
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_enable = 1'b1;
    i_up_push = 1'b1; i_down_push = 1'b0; i_up_level = 1'b1; i_down_level = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if ({o_move_up, o_move_down, o_active} !== 3'b000) begin
        errors++;
        $display("FAIL reset_hold c=%0d got up/dn/act=%b%b%b want 000", c, o_move_up, o_move_down, o_active);
      end
    end
    i_reset = 1'b0; i_up_push = 1'b0;
    step();
    checks++;
    if ({o_move_up, o_move_down, o_active} !== 3'b000) begin
      errors++;
      $display("FAIL reset_release got up/dn/act=%b%b%b want 000", o_move_up, o_move_down, o_active);
    end
    i_enable = 1'b0; i_up_push = 1'b1;
    step();
    checks++;
    if ({o_move_up, o_move_down, o_active} !== 3'b000) begin
      errors++;
      $display("FAIL disabled_push got up/dn/act=%b%b%b want 000", o_move_up, o_move_down, o_active);
    end
    i_enable = 1'b1; i_up_push = 1'b0;
    step();
    checks++;
    if ({o_move_up, o_move_down, o_active} !== 3'b000) begin
      errors++;
      $display("FAIL reenable_level got up/dn/act=%b%b%b want 000", o_move_up, o_move_down, o_active);
    end
  endtask

  // drop_at < 0: hold until the end; otherwise level falls from that cycle
  task automatic test_hold(input int drop_at, input int last);
    logic eu, ea;
    do_reset();
    for (int c = 0; c <= last; c++) begin
      if (drop_at < 0) eu = (c == 1 || c == 11 || c == 15 || c == 19 || c == 23 || c == 27);
      else             eu = (c == 1 || c == 11);
      ea = (c >= 1) && (drop_at < 0 || c <= drop_at);
      checks++;
      if (o_move_up !== eu || o_move_down !== 1'b0 || o_active !== ea) begin
        errors++;
        $display("FAIL hold_drop%0d c=%0d got up/dn/act=%b%b%b want %b0%b", drop_at, c, o_move_up, o_move_down, o_active, eu, ea);
      end
      i_up_push  = (c == 0);
      i_up_level = (c >= 1) && (drop_at < 0 || c < drop_at);
      step();
    end
  endtask

  task automatic test_both_push();
    do_reset();
    for (int c = 0; c <= 12; c++) begin
      checks++;
      if ({o_move_up, o_move_down, o_active} !== 3'b000) begin
        errors++;
        $display("FAIL both_push c=%0d got up/dn/act=%b%b%b want 000", c, o_move_up, o_move_down, o_active);
      end
      i_up_push = (c == 0); i_down_push = (c == 0);
      i_up_level = (c >= 1); i_down_level = (c >= 1);
      step();
    end
  endtask

  task automatic test_reverse();
    logic eu, ed;
    do_reset();
    for (int c = 0; c <= 29; c++) begin
      eu = (c == 1);
      ed = (c == 6 || c == 16 || c == 20 || c == 24 || c == 28);
      checks++;
      if (o_move_up !== eu || o_move_down !== ed || o_active !== (c >= 1)) begin
        errors++;
        $display("FAIL reverse c=%0d got up/dn/act=%b%b%b want %b%b%b", c, o_move_up, o_move_down, o_active, eu, ed, c >= 1);
      end
      i_up_push = (c == 0); i_up_level = (c >= 1);
      i_down_push = (c == 5); i_down_level = (c >= 5);
      step();
    end
  endtask

  task automatic test_same_push();
    do_reset();
    for (int c = 0; c <= 13; c++) begin
      checks++;
      if (o_move_up !== (c == 1 || c == 11) || o_move_down !== 1'b0 || o_active !== (c >= 1)) begin
        errors++;
        $display("FAIL same_push c=%0d got up/dn/act=%b%b%b want %b0%b", c, o_move_up, o_move_down, o_active, c == 1 || c == 11, c >= 1);
      end
      i_up_push = (c == 0 || c == 5); i_up_level = (c >= 1);
      step();
    end
  endtask

  task automatic test_grace();
    do_reset();
    for (int c = 0; c <= 12; c++) begin
      checks++;
      if (o_move_up !== (c == 1 || c == 11) || o_active !== (c >= 1)) begin
        errors++;
        $display("FAIL grace c=%0d got up/act=%b%b want %b%b", c, o_move_up, o_active, c == 1 || c == 11, c >= 1);
      end
      i_up_push = (c == 0); i_up_level = (c >= 2);
      step();
    end
  endtask

  // use_reset=0: i_enable low in cycle 16; use_reset=1: i_reset high in cycle 16
  task automatic test_stop(input bit use_reset);
    logic eu;
    do_reset();
    for (int c = 0; c <= 27; c++) begin
      eu = (c == 1 || c == 11 || c == 15 || c == 27);
      checks++;
      if (o_move_up !== eu || o_move_down !== 1'b0 || o_active !== ((c >= 1 && c <= 16) || c == 27)) begin
        errors++;
        $display("FAIL stop_rst%0d c=%0d got up/dn/act=%b%b%b want %b0%b", use_reset, c, o_move_up, o_move_down, o_active, eu, (c >= 1 && c <= 16) || c == 27);
      end
      i_up_push  = (c == 0 || c == 26);
      i_up_level = (c >= 1);
      i_enable   = use_reset || (c != 16);
      i_reset    = use_reset && (c == 16);
      step();
    end
  endtask

  initial begin
    clear_inputs();
    i_reset = 1'b0;
    test_reset();
    test_hold(-1, 30);
    test_hold(14, 20);
    test_both_push();
    test_reverse();
    test_same_push();
    test_grace();
    test_stop(1'b0);
    test_stop(1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
